// File: rtl/fir_coeff_ctrl.sv
// fir_coeff_ctrl: shadows a serial coefficient set, then swaps it into the
// fir datapath via flush -> clr -> load, and gates samples into fir_in.
// Ports: clk, rst_n (async, active-low); cw_valid/cw_ready/cw_data/cw_last
// coefficient stream; s_valid/s_ready/s_data sample stream; fir_clr,
// fir_coeff, fir_coeff_valid, fir_in to the filter; busy, err_len status.
// Build option: FIR_CTRL_FLUSH_EN enables the zero-flush DRAIN state.
module fir_coeff_ctrl #(
   parameter int SAMPLE_WIDTH = 16,
   parameter int COEFF_WIDTH  = 16,
   parameter int N_TAPS       = 41,
   parameter int FLUSH_CYCLES = 2 * N_TAPS
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           cw_valid,
   output logic                           cw_ready,
   input  logic signed [COEFF_WIDTH-1:0]  cw_data,
   input  logic                           cw_last,
   input  logic                           s_valid,
   output logic                           s_ready,
   input  logic signed [SAMPLE_WIDTH-1:0] s_data,
   output logic                           fir_clr,
   output logic signed [COEFF_WIDTH-1:0]  fir_coeff [N_TAPS:0],
   output logic                           fir_coeff_valid,
   output logic signed [SAMPLE_WIDTH-1:0] fir_in,
   output logic                           busy,
   output logic                           err_len
);

   localparam int IW = $clog2(N_TAPS + 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(N_TAPS);

   typedef enum logic [1:0] {RUN, DRAIN, CLR, LOAD} state_t;

   state_t state, state_nxt;
   logic [IW-1:0] idx;
   logic signed [COEFF_WIDTH-1:0] shadow [N_TAPS:0];
   logic cw_take, at_last, set_done, set_bad;

   assign cw_ready = (state == RUN);
   assign s_ready  = (state == RUN);
   assign busy     = (state != RUN);

   assign cw_take  = cw_valid && (state == RUN);
   assign at_last  = (idx == LAST_IDX);
   assign set_done = cw_take && cw_last && at_last;
   // Length error: cw_last and the final index must coincide.
   assign set_bad  = cw_take && (cw_last != at_last);

`ifdef FIR_CTRL_FLUSH_EN
   logic [9:0] flush_cnt;
   logic       flush_done;

   assign flush_done = (flush_cnt == 10'(FLUSH_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flush_cnt <= '0;
      end else if (state == DRAIN && !flush_done) begin
         flush_cnt <= flush_cnt + 10'd1;
      end else begin
         flush_cnt <= '0;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         RUN: begin
            if (set_done) begin
`ifdef FIR_CTRL_FLUSH_EN
               state_nxt = DRAIN;
`else
               state_nxt = CLR;
`endif
            end
         end
`ifdef FIR_CTRL_FLUSH_EN
         DRAIN: begin
            if (flush_done) begin
               state_nxt = CLR;
            end
         end
`endif
         CLR:     state_nxt = LOAD;
         LOAD:    state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx             <= '0;
         err_len         <= 1'b0;
         fir_clr         <= 1'b0;
         fir_coeff_valid <= 1'b0;
         fir_in          <= '0;
      end else begin
         err_len         <= set_bad;
         // Strobes decoded from next state so they line up with CLR/LOAD.
         fir_clr         <= (state_nxt == CLR);
         fir_coeff_valid <= (state_nxt == LOAD);
         // Filter runs every cycle: bubbles and swaps feed zeros.
         fir_in          <= (cw_ready && s_valid) ? s_data : '0;
         if (cw_take) begin
            idx <= (cw_last || at_last) ? '0 : idx + IW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k <= N_TAPS; k++) begin
            shadow[k]    <= '0;
            fir_coeff[k] <= '0;
         end
      end else begin
         if (cw_take) begin
            shadow[idx] <= cw_data;
         end
         if (state_nxt == LOAD) begin
            for (int k = 0; k <= N_TAPS; k++) begin
               fir_coeff[k] <= shadow[k];
            end
         end
      end
   end

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// tb_fir_coeff_ctrl: self-checking bench for fir_coeff_ctrl.
// Sample scoreboard plus cycle-exact swap, error and reset checks.
module tb_fir_coeff_ctrl;

   localparam int SW = 16;
   localparam int CW = 16;
   localparam int NT = 41;
   localparam int FC = 82;
`ifdef FIR_CTRL_FLUSH_EN
   localparam int FL = FC;
`else
   localparam int FL = 0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   logic cw_valid, cw_ready, cw_last;
   logic signed [CW-1:0] cw_data;
   logic s_valid, s_ready;
   logic signed [SW-1:0] s_data;
   logic fir_clr, fir_coeff_valid, busy, err_len;
   logic signed [CW-1:0] fir_coeff [NT:0];
   logic signed [SW-1:0] fir_in;

   int checks = 0;
   int errors = 0;
   logic [15:0] exp_q [$];
   logic [15:0] exp_coeff [NT:0];

   fir_coeff_ctrl #(
      .SAMPLE_WIDTH(SW),
      .COEFF_WIDTH (CW),
      .N_TAPS      (NT),
      .FLUSH_CYCLES(FC)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .cw_valid       (cw_valid),
      .cw_ready       (cw_ready),
      .cw_data        (cw_data),
      .cw_last        (cw_last),
      .s_valid        (s_valid),
      .s_ready        (s_ready),
      .s_data         (s_data),
      .fir_clr        (fir_clr),
      .fir_coeff      (fir_coeff),
      .fir_coeff_valid(fir_coeff_valid),
      .fir_in         (fir_in),
      .busy           (busy),
      .err_len        (err_len)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got,
                      input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sb_pop();
      chk("sb_depth", 16'(exp_q.size()), 16'd1);
      if (exp_q.size() > 0) chk("fir_in", fir_in, exp_q.pop_front());
   endtask

   task automatic chk_coeff(input string tag);
      for (int k = 0; k <= NT; k++) chk(tag, fir_coeff[k], exp_coeff[k]);
   endtask

   task automatic chk_rst(input string tag);
      chk({tag, "_cw_ready"}, cw_ready, 1);
      chk({tag, "_s_ready"}, s_ready, 1);
      chk({tag, "_clr"}, fir_clr, 0);
      chk({tag, "_cvld"}, fir_coeff_valid, 0);
      chk({tag, "_fir_in"}, fir_in, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_err"}, err_len, 0);
      chk_coeff({tag, "_coeff"});
   endtask

   task automatic send_sample(input logic v, input logic [15:0] d);
      s_valid = v;
      s_data  = d;
      chk("s_ready", s_ready, 1);
      exp_q.push_back(v ? d : 16'h0);
      step();
      s_valid = 1'b0;
      sb_pop();
   endtask

   task automatic beat(input logic [15:0] d, input logic last,
                       input logic err);
      logic       sv;
      logic [15:0] sd;
      sv = 1'($urandom_range(0, 1));
      sd = 16'($urandom);
      cw_valid = 1'b1;
      cw_data  = d;
      cw_last  = last;
      s_valid  = sv;
      s_data   = sd;
      chk("cw_ready", cw_ready, 1);
      exp_q.push_back(sv ? sd : 16'h0);
      step();
      cw_valid = 1'b0;
      cw_last  = 1'b0;
      s_valid  = 1'b0;
      sb_pop();
      chk("err_len", err_len, err);
   endtask

   task automatic send_set(input logic [15:0] base, input int n,
                           input logic lst);
      logic last, err;
      for (int k = 0; k < n; k++) begin
         last = lst && (k == n - 1);
         err  = (k == n - 1) && ((lst && n != NT + 1) || (!lst && n == NT + 1));
         beat(base + 16'(k), last, err);
      end
   endtask

   // Entered one cycle after the completing beat (cycle T+1).
   task automatic swap_watch(input logic [15:0] base, input logic hold);
      cw_valid = hold;
      cw_data  = 16'h0100;
      cw_last  = 1'b0;
      s_valid  = 1'b1;
      s_data   = 16'h1234;
      for (int c = 1; c <= FL + 3; c++) begin
         if (c >= 2) chk("flush_in", fir_in, 0);
         chk("sw_busy", busy, (c <= FL + 2));
         chk("sw_s_ready", s_ready, (c > FL + 2));
         chk("sw_cw_ready", cw_ready, (c > FL + 2));
         chk("sw_clr", fir_clr, (c == FL + 1));
         chk("sw_cvld", fir_coeff_valid, (c == FL + 2));
         if (c == FL + 2) begin
            for (int k = 0; k <= NT; k++) exp_coeff[k] = base + 16'(k);
            chk_coeff("coeff_new");
         end
         if (c < FL + 3) step();
      end
      s_valid = 1'b0;
   endtask

   task automatic idle_watch(input int n);
      for (int c = 0; c < n; c++) begin
         chk("idle_clr", fir_clr, 0);
         chk("idle_cvld", fir_coeff_valid, 0);
         chk("idle_busy", busy, 0);
         step();
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      cw_valid = 1'b0;
      cw_data  = '0;
      cw_last  = 1'b0;
      s_valid  = 1'b0;
      s_data   = '0;
      for (int k = 0; k <= NT; k++) exp_coeff[k] = 16'h0;
      repeat (3) step();
      chk_rst("rst");
      rst_n = 1'b1;
      step();

      send_sample(1'b1, 16'h7FFF);
      send_sample(1'b1, 16'h8000);
      send_sample(1'b1, 16'h0005);
      send_sample(1'b0, 16'hBEEF);
      for (int i = 0; i < 8; i++) begin
         send_sample(1'($urandom_range(0, 1)), 16'($urandom));
      end

      send_set(16'h0001, NT + 1, 1'b1);
      swap_watch(16'h0001, 1'b1);
      send_set(16'h0100, NT + 1, 1'b1);
      swap_watch(16'h0100, 1'b0);

      send_set(16'h0500, 10, 1'b1);
      idle_watch(5);
      send_set(16'h0600, NT + 1, 1'b0);
      idle_watch(5);
      chk_coeff("coeff_keep");

      send_set(16'h0A00, NT + 1, 1'b1);
      repeat (FL / 2) step();
      chk("mid_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      for (int k = 0; k <= NT; k++) exp_coeff[k] = 16'h0;
      chk_rst("midrst");
      step();
      rst_n = 1'b1;
      idle_watch(FL + 6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fir_coeff_ctrl.md
# fir_coeff_ctrl

Sequencing controller in front of the `fir` datapath that owns coefficient reprogramming. It receives a serial coefficient stream and buffers a complete set in a shadow bank, without disturbing live filtering. It then swaps the set in with a safe sequence: flush the delay line with zeros, assert `clr`, then present the new coefficients with a one-cycle `coeff_valid`. It also gates the input sample stream into `fir_in`, inserting zeros on bubbles and while a swap is in progress.

## Interface
- `SAMPLE_WIDTH`, 16, sample width into the filter
- `COEFF_WIDTH`, 16, coefficient width
- `N_TAPS`, 41, filter order; a set has N_TAPS+1 coefficients (index 0..N_TAPS)
- `FLUSH_CYCLES`, 82 (2*N_TAPS), number of zero samples driven before `clr`; legal range 1..1023
- `clk`  in  1  operating clock; all logic on the rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `cw_valid`  in  1  coefficient write beat valid
- `cw_ready`  out  1  coefficient write accept
- `cw_data`  in  COEFF_WIDTH  signed coefficient; beat k carries index k
- `cw_last`  in  1  final beat of a set
- `s_valid`  in  1  input sample valid
- `s_ready`  out  1  input sample accept
- `s_data`  in  SAMPLE_WIDTH  signed input sample
- `fir_clr`  out  1  to `fir.clr`
- `fir_coeff`  out  COEFF_WIDTH x (N_TAPS+1)  unpacked array [N_TAPS:0], to `fir.coeff_in`
- `fir_coeff_valid`  out  1  to `fir.coeff_valid`
- `fir_in`  out  SAMPLE_WIDTH  to `fir.fir_in`
- `busy`  out  1  high in any state other than RUN
- `err_len`  out  1  one-cycle pulse on a malformed coefficient set

## Operation
- FSM states are RUN, DRAIN, CLR and LOAD. Reset state is RUN.
- **RUN**
  - `cw_ready`=1 and `s_ready`=1.
  - On each accepted coefficient beat: `shadow[idx]`<=`cw_data`.
  - If `cw_last` and `idx`==N_TAPS, the set is complete: set `idx`<=0 and go to DRAIN.
  - If `cw_last` and `idx`<N_TAPS: pulse `err_len`, set `idx`<=0, discard the partial set (shadow beats written so far stay, but no swap occurs), stay in RUN.
  - If `idx`==N_TAPS and not `cw_last`: pulse `err_len`, set `idx`<=0, stay in RUN.
  - Otherwise `idx`<=`idx`+1.
  - Samples: every edge, `fir_in` <= (`s_valid` ? `s_data` : 0). The filter is clocked every cycle, so a bubble enters as a zero sample.
- **DRAIN**
  - `cw_ready`=0, `s_ready`=0, `fir_in`<=0.
  - A 10-bit flush counter runs from 0 to FLUSH_CYCLES-1, then the FSM goes to CLR.
- **CLR**: `fir_clr`=1 for exactly one cycle, then go to LOAD.
- **LOAD**
  - `fir_coeff`<=`shadow` (all N_TAPS+1 entries) and `fir_coeff_valid`=1 for exactly one cycle, then go to RUN.
  - `fir_coeff` holds its value until the next LOAD.
- `fir_clr` and `fir_coeff_valid` are registered outputs, decoded from the next state.
- `busy` = (state != RUN).
- Simultaneous events:
  - A completing `cw_last` beat and an accepted sample in the same RUN cycle are both taken. That sample is the last one before the flush.
  - `cw_valid` asserted outside RUN is not accepted; the sender holds its data.
- Reset, including mid-swap, forces RUN with `idx`=0 and the flush counter at 0. The shadow bank and `fir_coeff` are cleared to 0. Any in-flight swap is abandoned.

## Timing
- Reset values: `cw_ready`=1, `s_ready`=1, `fir_clr`=0, `fir_coeff_valid`=0, `fir_coeff`=all 0, `fir_in`=0, `busy`=0, `err_len`=0.
- Sample latency is 1 cycle: `s_data` accepted at edge E appears on `fir_in` after edge E.
- Edge T is the one accepting the completing `cw_last` beat. From that edge:
  - DRAIN occupies cycles T+1..T+FLUSH_CYCLES.
  - `fir_clr` is high in cycle T+FLUSH_CYCLES+1.
  - `fir_coeff_valid` is high and the new `fir_coeff` is visible in cycle T+FLUSH_CYCLES+2.
  - RUN, `s_ready` and `cw_ready` return in cycle T+FLUSH_CYCLES+3.
- `err_len` is high in the cycle following the offending beat.

## Configuration
- `FIR_CTRL_FLUSH_EN`
  - Defined: DRAIN state present, behaviour as above.
  - Undefined: DRAIN and the flush counter are removed. A completing set goes directly RUN→CLR, so `fir_clr` is high in cycle T+1, `fir_coeff_valid` in T+2, and RUN resumes in T+3.
  - `FLUSH_CYCLES` is ignored when the macro is undefined.

## Test plan
- Reset release, then 42 beats of value 0x0001..0x002A with `cw_last` on the 42nd (macro on) -> `fir_in`=0 for 82 cycles, `fir_clr` pulse at T+83, `fir_coeff[k]`=k+1 with `fir_coeff_valid` at T+84, `s_ready`=1 at T+85.
- Stream samples 0x7FFF,0x8000,0x0005 with `s_valid` high, then one idle cycle -> `fir_in` = 0x7FFF,0x8000,0x0005,0x0000 each one cycle after acceptance.
- Malformed sets: `cw_last` on beat 10, and a separate 42-beat set with no `cw_last` -> `err_len` pulse in each case, `fir_clr` never asserted, `fir_coeff` unchanged.
- `cw_valid` held through DRAIN/CLR/LOAD -> `cw_ready`=0 there; the first beat is accepted in the first RUN cycle and lands at index 0.
- Assert `rst_n` low in the middle of DRAIN -> all outputs take reset values immediately, `fir_coeff`=0, no `fir_clr` pulse afterwards.
- Macro undefined, complete set at edge T -> `fir_clr` in T+1, `fir_coeff_valid` in T+2, no zero-flush cycles.
